// File: rtl/month_year_if.sv
// Month/year calendar bus: advance/load requests in, BCD calendar state and
// derived day limit out.
interface month_year_if;
   logic        increase;
   logic        load;
   logic [3:0]  ld_month1;
   logic [3:0]  ld_month0;
   logic [15:0] ld_year;
   logic [3:0]  month1;
   logic [3:0]  month0;
   logic [15:0] year;
   logic        leap;
   logic [3:0]  limit1;
   logic [3:0]  limit0;
   logic        over;
   logic        load_err;

   modport slave (
      input  increase, load, ld_month1, ld_month0, ld_year,
      output month1, month0, year, leap, limit1, limit0, over, load_err
   );

   modport master (
      output increase, load, ld_month1, ld_month0, ld_year,
      input  month1, month0, year, leap, limit1, limit0, over, load_err
   );
endinterface

// File: rtl/month_year.sv
// BCD month/year counter with leap-aware day limit and validated load.
// Latency: 1 cycle for load/increase; no backpressure, every request pulse is consumed.
module month_year #(
   parameter logic [7:0]  RST_MONTH = 8'h01,
   parameter logic [15:0] RST_YEAR  = 16'h2000
) (
   input  logic        clk_out,
   input  logic        rst_n,
   month_year_if.slave bus
);

   logic [3:0]  month1_q, month1_d;
   logic [3:0]  month0_q, month0_d;
   logic [15:0] year_q, year_d;
   logic        load_err_q, load_err_d;

   logic [15:0] year_inc;
   logic        carry;
   logic        month_ok;
   logic        year_ok;
   logic        load_ok;
   logic        month_is_12;
   logic        leap;
   logic [7:0]  limit;

   function automatic logic div4(input logic [7:0] t);
      logic [3:0] t1;
      logic [3:0] t0;
      t1 = t[7:4];
      t0 = t[3:0];
      return (~t1[0] & (t0 == 4'd0 || t0 == 4'd4 || t0 == 4'd8)) |
             ( t1[0] & (t0 == 4'd2 || t0 == 4'd6));
   endfunction

   always_comb begin
      carry    = 1'b1;
      year_inc = year_q;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (year_q[i*4 +: 4] == 4'd9) begin
               year_inc[i*4 +: 4] = 4'd0;
            end else begin
               year_inc[i*4 +: 4] = year_q[i*4 +: 4] + 4'd1;
               carry              = 1'b0;
            end
         end
      end
   end

   always_comb begin
      month_ok = (bus.ld_month1 == 4'd0 && bus.ld_month0 != 4'd0 && bus.ld_month0 <= 4'd9) ||
                 (bus.ld_month1 == 4'd1 && bus.ld_month0 <= 4'd2);
      year_ok  = (bus.ld_year[15:12] <= 4'd9) && (bus.ld_year[11:8] <= 4'd9) &&
                 (bus.ld_year[7:4]   <= 4'd9) && (bus.ld_year[3:0]  <= 4'd9);
      load_ok  = month_ok && year_ok;
   end

   assign month_is_12 = (month1_q == 4'd1) && (month0_q == 4'd2);

   always_comb begin
      month1_d   = month1_q;
      month0_d   = month0_q;
      year_d     = year_q;
      load_err_d = 1'b0;
      if (bus.load) begin
         if (load_ok) begin
            month1_d = bus.ld_month1;
            month0_d = bus.ld_month0;
            year_d   = bus.ld_year;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.increase) begin
         if (month_is_12) begin
            month1_d = 4'd0;
            month0_d = 4'd1;
            year_d   = year_inc;
         end else if (month0_q == 4'd9) begin
            month1_d = month1_q + 4'd1;
            month0_d = 4'd0;
         end else begin
            month0_d = month0_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_out) begin
      if (!rst_n) begin
         month1_q   <= RST_MONTH[7:4];
         month0_q   <= RST_MONTH[3:0];
         year_q     <= RST_YEAR;
         load_err_q <= 1'b0;
      end else begin
         month1_q   <= month1_d;
         month0_q   <= month0_d;
         year_q     <= year_d;
         load_err_q <= load_err_d;
      end
   end

   // A century year (yy==00) is leap only when the century itself divides by 4.
   assign leap = (year_q[7:0] != 8'h00) ? div4(year_q[7:0]) : div4(year_q[15:8]);

   always_comb begin
      case ({month1_q, month0_q})
         8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: limit = 8'h31;
         8'h04, 8'h06, 8'h09, 8'h11:                      limit = 8'h30;
         8'h02:                                           limit = leap ? 8'h29 : 8'h28;
         default:                                         limit = 8'h00;
      endcase
   end

   assign bus.month1   = month1_q;
   assign bus.month0   = month0_q;
   assign bus.year     = year_q;
   assign bus.leap     = leap;
   assign bus.limit1   = limit[7:4];
   assign bus.limit0   = limit[3:0];
   assign bus.load_err = load_err_q;
   assign bus.over     = rst_n & bus.increase & ~bus.load & month_is_12 & (year_q == 16'h9999);

endmodule
